// File: rtl/tft_spi_tx_pkg.sv
// Shared definitions for the TFT SPI byte transmitter and the renderers
// feeding it: FSM state encoding and the panel command bytes every
// renderer uses to open a window and start a pixel write.
package tft_spi_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2
    } state_e;

    localparam logic [7:0] TFT_CMD_CASET = 8'h2A;  // column address set
    localparam logic [7:0] TFT_CMD_RASET = 8'h2B;  // row address set
    localparam logic [7:0] TFT_CMD_RAMWR = 8'h2C;  // memory write

endpackage

// File: rtl/tft_spi_tx_if.sv
// Byte request handshake between a renderer and the SPI transmitter.
//   tft_transmit : one-cycle request pulse (master -> slave)
//   tft_dc       : 0 = command byte, 1 = data byte (master -> slave)
//   tft_data     : byte to send (master -> slave)
//   tft_busy     : byte in flight (slave -> master)
interface tft_if;
    logic       tft_transmit;
    logic       tft_dc;
    logic [7:0] tft_data;
    logic       tft_busy;

    modport master (output tft_transmit, output tft_dc, output tft_data, input tft_busy);
    modport slave  (input tft_transmit, input tft_dc, input tft_data, output tft_busy);
endinterface

// File: rtl/tft_spi_tx_spi_clk_div.sv
// SCK half-period divider. Counts clk cycles while enabled and raises
// tick_o in the last cycle of each half-period, then wraps to 0.
//   clk, rst : system clock, synchronous active-high reset
//   clr_i    : hold the counter at 0 (used while the transmitter is idle)
//   en_i     : count this cycle
//   tick_o   : half-period ends this cycle (combinational, internal use)
module spi_clk_div #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tick_o
);
    localparam int DW = $clog2(CLK_DIV + 1);

    logic [DW-1:0] div_cnt_q;

    assign tick_o = en_i && (div_cnt_q == DW'(CLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            div_cnt_q <= '0;
        end else if (en_i) begin
            div_cnt_q <= tick_o ? '0 : div_cnt_q + 1'b1;
        end
    end
endmodule

// File: rtl/tft_spi_tx.sv
// Byte-level SPI (mode 0, MSB first) transmitter for a 4-wire TFT panel.
// Accepts one byte per tft_transmit pulse when idle, shifts it out over
// 16*CLK_DIV cycles and keeps CS low for CS_HOLD idle cycles afterwards so
// back-to-back bytes from a renderer share one CS assertion.
//   clk, rst : system clock, synchronous active-high reset
//   tft      : renderer handshake (slave side)
//   spi_sck  : serial clock, idle low
//   spi_mosi : serial data, changes only with SCK falling or at accept
//   spi_cs   : chip select, active low
//   spi_dc   : D/C line, latched at accept
module tft_spi_tx
    import tft_spi_tx_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter int CS_HOLD = 8
) (
    input  logic  clk,
    input  logic  rst,
    tft_if.slave  tft,
    output logic  spi_sck,
    output logic  spi_mosi,
    output logic  spi_cs,
    output logic  spi_dc
);
    localparam int IW = $clog2(CS_HOLD + 1);

    state_e        state_q;
    logic          busy_q, sck_q, mosi_q, cs_q, dc_q;
    logic [6:0]    shift_q;   // bits still to send after the one on MOSI
    logic [2:0]    bit_q;
    logic [IW-1:0] idle_q;
    logic          tick;

    spi_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (state_q == ST_IDLE),
        .en_i   (state_q != ST_IDLE),
        .tick_o (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b0;
            cs_q    <= 1'b1;
            dc_q    <= 1'b0;
            shift_q <= '0;
            bit_q   <= '0;
            idle_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // A request always beats CS expiry in the same cycle.
                    if (tft.tft_transmit) begin
                        shift_q <= tft.tft_data[6:0];
                        mosi_q  <= tft.tft_data[7];
                        dc_q    <= tft.tft_dc;
                        cs_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        bit_q   <= '0;
                        idle_q  <= '0;
                        state_q <= ST_LO;
                    end else if (!cs_q) begin
                        if (idle_q == IW'(CS_HOLD - 1)) begin
                            cs_q   <= 1'b1;
                            idle_q <= '0;
                        end else begin
                            idle_q <= idle_q + 1'b1;
                        end
                    end
                end
                ST_LO: begin
                    if (tick) begin
                        sck_q   <= 1'b1;
                        state_q <= ST_HI;
                    end
                end
                ST_HI: begin
                    if (tick) begin
                        sck_q <= 1'b0;
                        if (bit_q == 3'd7) begin
                            busy_q  <= 1'b0;
                            idle_q  <= '0;
                            state_q <= ST_IDLE;
                        end else begin
                            // Next bit goes out on the falling edge, giving a
                            // full half-period of setup before the next rise.
                            mosi_q  <= shift_q[6];
                            shift_q <= {shift_q[5:0], 1'b0};
                            bit_q   <= bit_q + 3'd1;
                            state_q <= ST_LO;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign tft.tft_busy = busy_q;
    assign spi_sck      = sck_q;
    assign spi_mosi     = mosi_q;
    assign spi_cs       = cs_q;
    assign spi_dc       = dc_q;
endmodule

// File: tb/tb_tft_spi_tx.sv
module tb_tft_spi_tx;
    import tft_spi_tx_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tx = 1'b0;
    logic dc = 1'b0;
    logic [7:0] data = 8'h00;

    always #5 clk = ~clk;

    // Instance 0: CLK_DIV=2, CS_HOLD=4. Instance 1: CLK_DIV=1, CS_HOLD=8.
    tft_if ifa();
    tft_if ifb();
    assign ifa.tft_transmit = tx;
    assign ifa.tft_dc       = dc;
    assign ifa.tft_data     = data;
    assign ifb.tft_transmit = tx;
    assign ifb.tft_dc       = dc;
    assign ifb.tft_data     = data;

    logic a_sck, a_mosi, a_cs, a_dc, b_sck, b_mosi, b_cs, b_dc;
    logic [1:0] o_busy, o_sck, o_mosi, o_cs, o_dc;
    assign o_busy = {ifb.tft_busy, ifa.tft_busy};
    assign o_sck  = {b_sck, a_sck};
    assign o_mosi = {b_mosi, a_mosi};
    assign o_cs   = {b_cs, a_cs};
    assign o_dc   = {b_dc, a_dc};

    tft_spi_tx #(.CLK_DIV(2), .CS_HOLD(4)) u_a (
        .clk(clk), .rst(rst), .tft(ifa.slave),
        .spi_sck(a_sck), .spi_mosi(a_mosi), .spi_cs(a_cs), .spi_dc(a_dc));
    tft_spi_tx #(.CLK_DIV(1), .CS_HOLD(8)) u_b (
        .clk(clk), .rst(rst), .tft(ifb.slave),
        .spi_sck(b_sck), .spi_mosi(b_mosi), .spi_cs(b_cs), .spi_dc(b_dc));

    function automatic int cdv(input int i);
        return (i == 0) ? 2 : 1;
    endfunction
    function automatic int chv(input int i);
        return (i == 0) ? 4 : 8;
    endfunction

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input int i, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s dut%0d @%0t act=%0d exp=%0d", nm, i, $time, act, exp);
        end
    endtask

    // Reference model: k = cycles since accept (0 when idle). During a byte,
    // SCK is the parity of the half-period index and MOSI is the bit whose
    // full period contains the cycle.
    int         mk[2];
    int         midle[2];
    logic [7:0] md[2];
    logic       mdc[2], mcs[2], mmosi[2];
    int         run[2];
    bit         rst_seen[2];

    // Decoder on instance 0: assembles bytes from MOSI at SCK rising edges.
    logic [7:0] dbits;
    int         nb = 0;
    bit         dec_clr = 0;
    logic       prev_sck = 1'b0;
    logic [7:0] dec_q[$];
    bit         cs_hi_seen = 0;

    initial begin
        forever begin
            @(posedge clk);
            for (int i = 0; i < 2; i++) begin
                if (rst) begin
                    mk[i] = 0; mcs[i] = 1'b1; mdc[i] = 1'b0; mmosi[i] = 1'b0;
                    midle[i] = 0; rst_seen[i] = 1;
                end else if (mk[i] == 0) begin
                    if (tx) begin
                        mk[i] = 1; md[i] = data; mdc[i] = dc; mcs[i] = 1'b0;
                        midle[i] = 0; mmosi[i] = data[7];
                    end else if (!mcs[i]) begin
                        midle[i]++;
                        if (midle[i] == chv(i)) begin
                            mcs[i] = 1'b1; midle[i] = 0;
                        end
                    end
                end else begin
                    mk[i]++;
                    if (mk[i] > 16 * cdv(i)) mk[i] = 0;
                    else mmosi[i] = md[i][7 - ((mk[i] - 1) / (2 * cdv(i)))];
                end
            end
            if (rst) dec_clr = 1;

            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                chk("busy", i, o_busy[i], (mk[i] != 0) ? 1 : 0);
                chk("sck",  i, o_sck[i],  (mk[i] != 0) ? (((mk[i] - 1) / cdv(i)) % 2) : 0);
                chk("mosi", i, o_mosi[i], mmosi[i]);
                chk("cs",   i, o_cs[i],   mcs[i]);
                chk("dc",   i, o_dc[i],   mdc[i]);
                if (o_busy[i]) run[i]++;
                else begin
                    if (run[i] > 0 && !rst_seen[i]) chk("busy_len", i, run[i], 16 * cdv(i));
                    run[i] = 0;
                    rst_seen[i] = 0;
                end
            end
            if (dec_clr) begin nb = 0; dec_clr = 0; end
            if (o_sck[0] && !prev_sck) begin
                dbits = {dbits[6:0], o_mosi[0]};
                nb++;
                if (nb == 8) begin dec_q.push_back(dbits); nb = 0; end
            end
            prev_sck = o_sck[0];
            if (o_cs[0]) cs_hi_seen = 1;
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (o_busy[0] && n < 1000) begin @(negedge clk); n++; end
        chk("idle_timeout", 0, o_busy[0], 0);
    endtask

    task automatic send(input logic [7:0] d, input logic c);
        wait_idle();
        tx = 1'b1; data = d; dc = c;
        @(negedge clk);
        tx = 1'b0;
    endtask

    task automatic chk_dec(input string nm, input logic [7:0] exp[$]);
        chk({nm, "_count"}, 0, dec_q.size(), exp.size());
        for (int j = 0; j < exp.size() && j < dec_q.size(); j++)
            chk({nm, "_byte"}, 0, dec_q[j], exp[j]);
        dec_q.delete();
    endtask

    initial begin
        logic [7:0] e[$];
        int n;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", 0, o_busy[0], 0);
        chk("rst_sck",  0, o_sck[0], 0);
        chk("rst_mosi", 0, o_mosi[0], 0);
        chk("rst_cs",   0, o_cs[0], 1);
        chk("rst_dc",   0, o_dc[0], 0);
        dec_q.delete();

        // Single command byte.
        send(TFT_CMD_CASET, 1'b0);
        chk("cs_fall", 0, o_cs[0], 0);
        chk("busy_rise", 0, o_busy[0], 1);
        wait_idle();
        e = '{8'h2A};
        chk_dec("caset", e);
        repeat (12) @(negedge clk);

        // Renderer-style burst, back-to-back.
        send(TFT_CMD_RAMWR, 1'b0);
        cs_hi_seen = 0;
        send(8'hFF, 1'b1);
        send(8'h00, 1'b1);
        send(8'hC0, 1'b1);
        wait_idle();
        chk("burst_cs_low", 0, cs_hi_seen, 0);
        e = '{8'h2C, 8'hFF, 8'h00, 8'hC0};
        chk_dec("burst", e);

        // CS release gap after the last byte.
        n = 0;
        while (!o_cs[0] && n < 50) begin @(negedge clk); n++; end
        chk("cs_gap", 0, n, 4);
        repeat (10) @(negedge clk);

        // Request while busy is ignored.
        send(8'hA5, 1'b0);
        repeat (10) @(negedge clk);
        tx = 1'b1; data = 8'h55; dc = 1'b1;
        @(negedge clk);
        tx = 1'b0;
        wait_idle();
        chk("ignore_nb", 0, nb, 0);
        e = '{8'hA5};
        chk_dec("ignore", e);
        repeat (10) @(negedge clk);

        // Reset during bit 3 of 8'hF0, then a clean byte.
        send(8'hF0, 1'b1);
        repeat (13) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", 0, o_busy[0], 0);
        chk("abort_sck",  0, o_sck[0], 0);
        chk("abort_cs",   0, o_cs[0], 1);
        chk("abort_mosi", 0, o_mosi[0], 0);
        rst = 1'b0;
        @(negedge clk);
        dec_q.delete();
        send(8'h81, 1'b1);
        wait_idle();
        e = '{8'h81};
        chk_dec("after_rst", e);
        repeat (10) @(negedge clk);

        // Random traffic: requests at any time, occasional reset.
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            tx   = ($urandom_range(0, 3) == 0);
            data = 8'($urandom);
            dc   = 1'($urandom);
            rst  = ($urandom_range(0, 299) == 0);
        end
        @(negedge clk);
        tx = 1'b0; rst = 1'b0;
        repeat (60) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/tft_spi_tx.md
Name: tft_spi_tx

Overview:
- Byte-level SPI transmitter that sits directly downstream of the sprite/tile renderers.
- It consumes their {tft_transmit, tft_dc, tft_data} byte requests and answers with tft_busy.
- It drives a 4-wire SPI TFT controller: SCK, MOSI, CS, DC.
- SPI mode 0, MSB first, one byte per request; DC is held for the whole byte; CS is released after a programmable idle gap.

Parameters:
- CLK_DIV, 2: SCK half-period in clk cycles (>=1); one byte occupies 16*CLK_DIV cycles.
- CS_HOLD, 8: idle clk cycles after a byte before CS is deasserted (>=1).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- tft_transmit  input  1  one-cycle request pulse; byte and dc are valid in that cycle
- tft_dc  input  1  0 = command byte, 1 = data byte
- tft_data  input  8  byte to send
- tft_busy  output  1  high while a byte is being shifted
- spi_sck  output  1  serial clock, idle low
- spi_mosi  output  1  serial data
- spi_cs  output  1  chip select, active low
- spi_dc  output  1  D/C line to the panel

Behaviour:
- Reset values: tft_busy=0, spi_sck=0, spi_mosi=0, spi_cs=1, spi_dc=0; state=IDLE; all counters 0.
- Reset mid-byte aborts the byte at once, with the same values; no partial completion.
- All outputs are registered; no combinational path from input to output.
- States:
  - IDLE: tft_busy=0, sck=0.
    - On tft_transmit=1: shift_reg<=tft_data, spi_dc<=tft_dc, spi_mosi<=tft_data[7], spi_cs<=0, tft_busy<=1, div_cnt<=0, bit_cnt<=0 -> LO.
    - Otherwise, while spi_cs=0, idle_cnt increments. When idle_cnt reaches CS_HOLD-1, spi_cs<=1 and idle_cnt<=0.
  - LO: sck=0. When div_cnt==CLK_DIV-1: sck<=1, div_cnt<=0 -> HI; else div_cnt+1.
  - HI: sck=1. When div_cnt==CLK_DIV-1: sck<=0, div_cnt<=0.
    - If bit_cnt==7: tft_busy<=0, idle_cnt<=0 -> IDLE.
    - Else: shift left, spi_mosi<=next bit, bit_cnt+1 -> LO.
- Timing:
  - tft_busy is high for exactly 16*CLK_DIV cycles per byte, starting the cycle after the accept edge.
  - Exactly 8 rising SCK edges per byte.
  - MOSI changes only in the same cycle as an SCK falling edge, or at accept, so it is stable across every rising edge.
- Upstream handshake:
  - The requester pulses tft_transmit only when it sees ~tft_busy and its own transmit is low.
  - Busy rises one cycle after accept, so a one-cycle pulse is never double-accepted.
- Boundary conditions:
  - tft_transmit while tft_busy=1: ignored; the byte in flight and spi_dc are unchanged.
  - Back-to-back: a request in the first IDLE cycle after a byte is accepted immediately. CS stays low, giving 1 idle cycle between bytes.
  - A request in the same cycle idle_cnt expires wins: CS stays 0 and idle_cnt clears.
  - spi_dc changes only at accept, never mid-byte.
- Widths: div_cnt is clog2(CLK_DIV+1) bits; bit_cnt is 3 bits; idle_cnt is clog2(CS_HOLD+1) bits; no wrap inside a byte.

Decomposition:
- Shared header/package: state encoding localparams (ST_IDLE, ST_LO, ST_HI) and the TFT command constants 8'h2A, 8'h2B, 8'h2C used by every renderer.
- One natural sub-module, spi_clk_div: the div_cnt counter with a tick output on CLK_DIV-1. Everything else stays in tft_spi_tx.

Test Plan:
- CLK_DIV=2; pulse transmit with data=8'h2A, dc=0 -> MOSI at the 8 SCK rises = 0,0,1,0,1,0,1,0; spi_dc=0 throughout; tft_busy high for exactly 32 cycles; spi_cs falls the cycle after accept.
- Renderer-style driver sends 8'h2C (dc=0) then 8'hFF, 8'h00, 8'hC0 (dc=1) back-to-back:
  - spi_cs stays 0 across all four bytes;
  - spi_dc switches 0->1 only at the second accept;
  - decoded bytes match in order, none lost or duplicated.
- CS_HOLD=4; single byte, then no requests -> spi_cs rises exactly 4 cycles after tft_busy falls; sck stays 0.
- Pulse transmit with 8'h55 mid-byte, while sending 8'hA5 -> decoded byte is 8'hA5; no extra SCK edges; busy duration unchanged.
- Assert rst during bit 3 of 8'hF0 -> next cycle tft_busy=0, sck=0, cs=1, mosi=0; a subsequent 8'h81 transmits correctly.
- CLK_DIV=1 -> byte takes 16 cycles; SCK toggles every cycle; MOSI still stable at each rising edge.
